// File: rtl/branch_predict_unit_if.sv
// Fetch prediction and execute-resolution signals of the branch predictor.
// master = fetch/execute side, slave = branch_predict_unit.
interface branch_predict_unit_if;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_jalr;
  logic [31:0] ex_jalr_target;
  logic        flush;
  logic [31:0] redirect_pc;

  modport master (
    output fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target, ex_jalr, ex_jalr_target,
    input  predict_taken, predict_target, flush, redirect_pc
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target, ex_jalr, ex_jalr_target,
    output predict_taken, predict_target, flush, redirect_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: 2-bit BHT + direct-mapped BTB, mispredict flush/redirect.
// Optional BRANCH_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predict_unit_if.slave bus
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
`endif
);

  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - BTB_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  ctr_t              bht_q       [BHT_ENTRIES];
  ctr_t              bht_d       [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_d   [BTB_ENTRIES];
  logic [31:0]       btb_tgt_q   [BTB_ENTRIES];
  logic [31:0]       btb_tgt_d   [BTB_ENTRIES];

  logic [BHT_W-1:0]  f_bht_idx, x_bht_idx;
  logic [BTB_W-1:0]  f_btb_idx, x_btb_idx;
  logic [TAG_W-1:0]  f_tag, x_tag;
  logic              f_ctr_taken;
  logic              pred_hit;
  logic              train;
  logic              flush_c;
  logic [31:0]       redirect_c;
  logic              unused_pc_bits;

  assign f_bht_idx = bus.fetch_pc[BHT_W+1:2];
  assign f_btb_idx = bus.fetch_pc[BTB_W+1:2];
  assign f_tag     = bus.fetch_pc[31:BTB_W+2];
  assign x_bht_idx = bus.ex_pc[BHT_W+1:2];
  assign x_btb_idx = bus.ex_pc[BTB_W+1:2];
  assign x_tag     = bus.ex_pc[31:BTB_W+2];
  assign unused_pc_bits = ^bus.fetch_pc[1:0];

  // Prediction reads the registered tables, so a same-cycle write is seen next cycle.
  assign f_ctr_taken = (bht_q[f_bht_idx] == WT) || (bht_q[f_bht_idx] == ST);
  assign pred_hit    = !reset && f_ctr_taken && btb_valid_q[f_btb_idx] &&
                       (btb_tag_q[f_btb_idx] == f_tag);
  assign bus.predict_taken  = pred_hit;
  assign bus.predict_target = pred_hit ? btb_tgt_q[f_btb_idx] : '0;

  always_comb begin
    flush_c    = 1'b0;
    redirect_c = '0;
    if (!reset && bus.ex_valid) begin
      if (bus.ex_jalr) begin
        flush_c    = 1'b1;
        redirect_c = bus.ex_jalr_target & 32'hFFFF_FFFE;
      end else if (bus.ex_is_branch) begin
        if (bus.ex_taken != bus.ex_pred_taken) begin
          flush_c    = 1'b1;
          redirect_c = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
        end else if (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)) begin
          flush_c    = 1'b1;
          redirect_c = bus.ex_target;
        end
      end
    end
  end

  assign bus.flush       = flush_c;
  assign bus.redirect_pc = redirect_c;

  // A JALR flagged alongside a branch takes precedence and must not train.
  assign train = bus.ex_valid && bus.ex_is_branch && !bus.ex_jalr;

  always_comb begin
    bht_d       = bht_q;
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    if (train) begin
      unique case (bht_q[x_bht_idx])
        SNT: bht_d[x_bht_idx] = bus.ex_taken ? WNT : SNT;
        WNT: bht_d[x_bht_idx] = bus.ex_taken ? WT  : SNT;
        WT:  bht_d[x_bht_idx] = bus.ex_taken ? ST  : WNT;
        ST:  bht_d[x_bht_idx] = bus.ex_taken ? ST  : WT;
        default: bht_d[x_bht_idx] = WNT;
      endcase
      if (bus.ex_taken) begin
        btb_valid_d[x_btb_idx] = 1'b1;
        btb_tag_d[x_btb_idx]   = x_tag;
        btb_tgt_d[x_btb_idx]   = bus.ex_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bht_q       <= '{default: WNT};
      btb_valid_q <= '0;
    end else begin
      bht_q       <= bht_d;
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (bus.ex_valid && (bus.ex_is_branch || bus.ex_jalr) && (branch_count_q != '1))
      branch_count_d = branch_count_q + 32'd1;
    if (flush_c && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vector table, reset corner cases,
// then random traffic against a table-level behavioural model.
module tb_branch_predict_unit;

  localparam int unsigned BHT = 64;
  localparam int unsigned BTB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_unit_if bus ();

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_count, mispredict_count;
`endif

  branch_predict_unit #(
    .BHT_ENTRIES(BHT),
    .BTB_ENTRIES(BTB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_cnt [BHT];
  bit          m_bv  [BTB];
  logic [31:0] m_btag[BTB];
  logic [31:0] m_btgt[BTB];
  logic [31:0] m_bc, m_mc;

  function automatic logic [5:0] bhi(input logic [31:0] pc);
    return 6'((pc >> 2) % BHT);
  endfunction

  function automatic logic [3:0] bti(input logic [31:0] pc);
    return 4'((pc >> 2) % BTB);
  endfunction

  function automatic logic m_pt(input logic [31:0] pc);
    return !reset && (m_cnt[bhi(pc)] >= 2) && m_bv[bti(pc)] &&
           (m_btag[bti(pc)] == pc / (4 * BTB));
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pt(pc) ? m_btgt[bti(pc)] : 32'd0;
  endfunction

  function automatic logic m_flush();
    if (reset || !bus.ex_valid) return 1'b0;
    if (bus.ex_jalr) return 1'b1;
    if (!bus.ex_is_branch) return 1'b0;
    if (bus.ex_taken != bus.ex_pred_taken) return 1'b1;
    return bus.ex_taken && (bus.ex_pred_target != bus.ex_target);
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!m_flush()) return 32'd0;
    if (bus.ex_jalr) return {bus.ex_jalr_target[31:1], 1'b0};
    if (!bus.ex_taken) return bus.ex_pc + 32'd4;
    return bus.ex_target;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT; i++) m_cnt[i] <= 1;
      for (int i = 0; i < BTB; i++) m_bv[i] <= 1'b0;
      m_bc <= 32'd0;
      m_mc <= 32'd0;
    end else begin
      if (bus.ex_valid && (bus.ex_is_branch || bus.ex_jalr) && m_bc != 32'hFFFF_FFFF)
        m_bc <= m_bc + 32'd1;
      if (m_flush() && m_mc != 32'hFFFF_FFFF)
        m_mc <= m_mc + 32'd1;
      if (bus.ex_valid && bus.ex_is_branch && !bus.ex_jalr) begin
        if (bus.ex_taken) begin
          m_cnt[bhi(bus.ex_pc)]  <= (m_cnt[bhi(bus.ex_pc)] == 3) ? 3 : m_cnt[bhi(bus.ex_pc)] + 1;
          m_bv[bti(bus.ex_pc)]   <= 1'b1;
          m_btag[bti(bus.ex_pc)] <= bus.ex_pc / (4 * BTB);
          m_btgt[bti(bus.ex_pc)] <= bus.ex_target;
        end else begin
          m_cnt[bhi(bus.ex_pc)]  <= (m_cnt[bhi(bus.ex_pc)] == 0) ? 0 : m_cnt[bhi(bus.ex_pc)] - 1;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] fetch_pc, v, br, pc, tk, tgt, ptk, ptgt, jalr, jtgt;
    logic [31:0] e_pt, e_ptgt, e_fl, e_rd;
  } vec_t;

  vec_t tbl [20];

  task automatic drive(input vec_t r);
    bus.fetch_pc       = r.fetch_pc;
    bus.ex_valid       = r.v[0];
    bus.ex_is_branch   = r.br[0];
    bus.ex_pc          = r.pc;
    bus.ex_taken       = r.tk[0];
    bus.ex_target      = r.tgt;
    bus.ex_pred_taken  = r.ptk[0];
    bus.ex_pred_target = r.ptgt;
    bus.ex_jalr        = r.jalr[0];
    bus.ex_jalr_target = r.jtgt;
  endtask

  task automatic check_row(input string tag, input vec_t r);
    chk({tag, " predict_taken"},  32'(bus.predict_taken), r.e_pt);
    chk({tag, " predict_target"}, bus.predict_target,     r.e_ptgt);
    chk({tag, " flush"},          32'(bus.flush),         r.e_fl);
    chk({tag, " redirect_pc"},    bus.redirect_pc,        r.e_rd);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " predict_taken"},  32'(bus.predict_taken), 32'(m_pt(bus.fetch_pc)));
    chk({tag, " predict_target"}, bus.predict_target,     m_ptgt(bus.fetch_pc));
    chk({tag, " flush"},          32'(bus.flush),         32'(m_flush()));
    chk({tag, " redirect_pc"},    bus.redirect_pc,        m_redirect());
  endtask

  vec_t idle, r;

  initial begin
    //          fetch  v br  pc          tk tgt    ptk ptgt   j  jtgt   e_pt e_ptgt e_fl e_rd
    tbl[0]  = '{'h40,  0, 0, 0,          0, 0,     0, 0,     0, 0,     0, 0,     0, 0};
    tbl[1]  = '{'h40,  1, 1, 'h40,       1, 'h80,  0, 0,     0, 0,     0, 0,     1, 'h80};
    tbl[2]  = '{'h40,  0, 0, 0,          0, 0,     0, 0,     0, 0,     1, 'h80,  0, 0};
    tbl[3]  = '{'h40,  1, 1, 'h40,       0, 'h80,  1, 'h80,  0, 0,     1, 'h80,  1, 'h44};
    tbl[4]  = '{'h40,  0, 0, 0,          0, 0,     0, 0,     0, 0,     0, 0,     0, 0};
    tbl[5]  = '{'h40,  1, 1, 'h40,       1, 'h80,  0, 0,     0, 0,     0, 0,     1, 'h80};
    tbl[6]  = '{'h40,  1, 1, 'h80,       1, 'h200, 0, 0,     0, 0,     1, 'h80,  1, 'h200};
    tbl[7]  = '{'h40,  0, 0, 0,          0, 0,     0, 0,     0, 0,     0, 0,     0, 0};
    tbl[8]  = '{'h80,  0, 0, 0,          0, 0,     0, 0,     0, 0,     1, 'h200, 0, 0};
    tbl[9]  = '{'h80,  1, 1, 'h80,       1, 'h900, 0, 0,     1, 'h123, 1, 'h200, 1, 'h122};
    tbl[10] = '{'h80,  0, 0, 0,          0, 0,     0, 0,     0, 0,     1, 'h200, 0, 0};
    tbl[11] = '{'h80,  1, 1, 'h80,       1, 'h200, 1, 'h200, 0, 0,     1, 'h200, 0, 0};
    tbl[12] = '{'h80,  1, 1, 'h80,       1, 'h300, 1, 'h200, 0, 0,     1, 'h200, 1, 'h300};
    tbl[13] = '{'h80,  0, 0, 0,          0, 0,     0, 0,     0, 0,     1, 'h300, 0, 0};
    tbl[14] = '{'h80,  1, 1, 'hFFFFFFFC, 0, 'h10,  1, 'h10,  0, 0,     1, 'h300, 1, 0};
    tbl[15] = '{'h80,  0, 1, 'h80,       0, 0,     1, 'h300, 0, 0,     1, 'h300, 0, 0};
    tbl[16] = '{'h80,  1, 0, 'h80,       1, 'h300, 0, 0,     0, 0,     1, 'h300, 0, 0};
    tbl[17] = '{'h80,  1, 1, 'h80,       0, 0,     0, 0,     0, 0,     1, 'h300, 0, 0};
    tbl[18] = '{'h80,  1, 1, 'h80,       0, 0,     0, 0,     0, 0,     1, 'h300, 0, 0};
    tbl[19] = '{'h80,  0, 0, 0,          0, 0,     0, 0,     0, 0,     0, 0,     0, 0};
    idle    = '{'h40,  0, 0, 0,          0, 0,     0, 0,     0, 0,     0, 0,     0, 0};

    // Reset: outputs must read 0 even while a JALR resolves.
    reset = 1'b1;
    drive(idle);
    repeat (2) @(negedge clk);
    r = idle; r.v = 1; r.jalr = 1; r.jtgt = 'h123;
    drive(r);
    #1;
    check_row("in_reset", idle);
    @(negedge clk);
    reset = 1'b0;
    drive(idle);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_row($sformatf("row%0d", i), tbl[i]);
    end
`ifdef BRANCH_PERF_CNT_EN
    @(negedge clk);
    drive(idle);
    #1;
    chk("dir branch_count", branch_count, 32'd10);
    chk("dir mispredict_count", mispredict_count, 32'd7);
`endif

    // Reset in the same cycle as a training update: update must be dropped.
    @(negedge clk);
    reset = 1'b1;
    r = idle; r.fetch_pc = 'h80; r.v = 1; r.br = 1; r.pc = 'h80; r.tk = 1; r.tgt = 'h500;
    drive(r);
    #1;
    check_row("rst_upd", idle);
    @(negedge clk);
    reset = 1'b0;
    r = idle; r.fetch_pc = 'h80;
    drive(r);
    #1;
    check_row("post_rst", idle);
`ifdef BRANCH_PERF_CNT_EN
    chk("post_rst branch_count", branch_count, 32'd0);
    chk("post_rst mispredict_count", mispredict_count, 32'd0);
`endif
    // One taken resolve from the weakly-not-taken reset state is enough to predict.
    @(negedge clk);
    r = idle; r.fetch_pc = 'h80; r.v = 1; r.br = 1; r.pc = 'h80; r.tk = 1; r.tgt = 'h500;
    r.e_fl = 1; r.e_rd = 'h500;
    drive(r);
    #1;
    check_row("wnt_train", r);
    @(negedge clk);
    r = idle; r.fetch_pc = 'h80; r.e_pt = 1; r.e_ptgt = 'h500;
    drive(r);
    #1;
    check_row("wnt_pred", r);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
      bus.fetch_pc       = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 63) << 2);
      bus.ex_valid       = ($urandom_range(0, 9) != 0);
      bus.ex_is_branch   = ($urandom_range(0, 9) < 7);
      bus.ex_pc          = pc;
      bus.ex_taken       = $urandom_range(0, 1) == 1;
      bus.ex_target      = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 7) << 4);
      if ($urandom_range(0, 1) == 1) begin
        bus.ex_pred_taken  = m_pt(pc);
        bus.ex_pred_target = m_ptgt(pc);
      end else begin
        bus.ex_pred_taken  = $urandom_range(0, 1) == 1;
        bus.ex_pred_target = ($urandom_range(0, 7) << 4);
      end
      bus.ex_jalr        = ($urandom_range(0, 9) == 0);
      bus.ex_jalr_target = $urandom;
      #1;
      check_model($sformatf("rnd%0d", n));
    end
    @(negedge clk);
    reset = 1'b0;
    drive(idle);
    #1;
`ifdef BRANCH_PERF_CNT_EN
    chk("rnd branch_count", branch_count, m_bc);
    chk("rnd mispredict_count", mispredict_count, m_mc);
`endif
    check_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
